// File: rtl/bri_decoder.sv
// H-bridge gate decoder: maps the bridge code to four gate drives, inserting dead time on commutation.
// Optional feature macro: BRI_DEADTIME_EN (dead-time window and bri_busy; otherwise changes apply at once).
module bri_decoder #(
  parameter int DEAD_CYC = 4
) (
  input  logic       clk_dds,
  input  logic       rst_n,
  input  logic       clk_4f_en,
  input  logic [4:0] i,
  output logic [3:0] bri_gate,
  output logic       bri_busy,
  output logic [7:0] sw_cnt
);

  localparam logic [3:0] OFF  = 4'b0000;
  localparam logic [3:0] POS  = 4'b1001;
  localparam logic [3:0] NEG  = 4'b0110;
  localparam logic [3:0] FREE = 4'b0101;

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD} state_e;

  if (DEAD_CYC < 1 || DEAD_CYC > 15) begin : g_bad_dead_cyc
    $error("bri_decoder: DEAD_CYC must be in 1..15");
  end

  state_e     state_q;
  logic [3:0] gate_q;
  logic       tgl_q;
  logic [7:0] cnt_q;
  logic [3:0] tgt;
  logic       inc;

  // Target uses the pre-edge half toggle, so a 4f tick changes the drive one edge later.
  always_comb begin
    tgt = POS;
    if (!i[0])              tgt = OFF;
    else if (i[3])          tgt = OFF;
    else if (i[4])          tgt = FREE;
    else if (i[1] && tgl_q) tgt = FREE;
    else if (i[2])          tgt = NEG;
  end

`ifdef BRI_DEADTIME_EN
  logic       busy_q;
  logic [3:0] dcnt_q;
  assign inc      = (state_q == DEAD) && (dcnt_q == 4'd0) && (tgt != OFF);
  assign bri_busy = busy_q;
`else
  assign inc      = (state_q == DRIVE) && (tgt != gate_q) && (tgt != OFF);
  assign bri_busy = 1'b0;
`endif

  always_ff @(posedge clk_dds or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gate_q  <= OFF;
      tgl_q   <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef BRI_DEADTIME_EN
      busy_q  <= 1'b0;
      dcnt_q  <= 4'd0;
`endif
    end else begin
      if (clk_4f_en) tgl_q <= i[1] & ~tgl_q;

      // Stop clears the counter and takes precedence over any increment.
      if (!i[0])                       cnt_q <= 8'd0;
      else if (inc && cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;

      unique case (state_q)
        IDLE: begin
          if (tgt != OFF) begin
            gate_q  <= tgt;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (tgt == OFF) begin
            gate_q  <= OFF;
            state_q <= IDLE;
          end else if (tgt != gate_q) begin
`ifdef BRI_DEADTIME_EN
            gate_q  <= OFF;
            busy_q  <= 1'b1;
            dcnt_q  <= 4'(DEAD_CYC - 1);
            state_q <= DEAD;
`else
            gate_q  <= tgt;
`endif
          end
        end
`ifdef BRI_DEADTIME_EN
        DEAD: begin
          // Exit samples the latest target; changes during the window don't restart it.
          if (dcnt_q == 4'd0) begin
            busy_q <= 1'b0;
            if (tgt != OFF) begin
              gate_q  <= tgt;
              state_q <= DRIVE;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            dcnt_q <= dcnt_q - 4'd1;
          end
        end
`endif
        default: begin
          gate_q  <= OFF;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bri_gate = gate_q;
  assign sw_cnt   = cnt_q;

endmodule

// File: tb/tb_bri_decoder.sv
// Directed self-checking bench for bri_decoder; expectations follow the build's dead-time setting.
module tb_bri_decoder;

`ifdef BRI_DEADTIME_EN
  localparam int DT = 4;
`else
  localparam int DT = 0;
`endif

  logic       clk_dds = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clk_4f_en = 1'b0;
  logic [4:0] i = 5'b00000;
  logic [3:0] bri_gate;
  logic       bri_busy;
  logic [7:0] sw_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  bri_decoder #(.DEAD_CYC(4)) dut (
    .clk_dds  (clk_dds),
    .rst_n    (rst_n),
    .clk_4f_en(clk_4f_en),
    .i        (i),
    .bri_gate (bri_gate),
    .bri_busy (bri_busy),
    .sw_cnt   (sw_cnt)
  );

  always #5 clk_dds = ~clk_dds;

  // Shoot-through watchdog on every cycle.
  always @(negedge clk_dds) begin
    n_cmp++;
    assert (!((bri_gate[3] & bri_gate[2]) | (bri_gate[1] & bri_gate[0])))
    else begin
      n_fail++;
      $error("FAIL shoot_through: gate=%b required no hi&lo pair", bri_gate);
    end
  end

  task automatic tick();
    @(posedge clk_dds);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic [3:0] g, input logic b);
    chk({tag, "_gate"}, {4'd0, bri_gate}, {4'd0, g});
    chk({tag, "_busy"}, {7'd0, bri_busy}, {7'd0, b});
  endtask

  // Apply a code that forces a commutation and check the 0000 window then the new pattern.
  task automatic commute(input string tag, input logic [4:0] code, input logic [3:0] pat);
    i = code;
    for (int k = 0; k < DT; k++) begin
      tick();
      exp_out({tag, "_dead"}, 4'b0000, 1'b1);
    end
    tick();
    exp_out({tag, "_new"}, pat, 1'b0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick();
    exp_out("reset", 4'b0000, 1'b0);
    chk("reset_cnt", sw_cnt, 8'd0);
    #2 rst_n = 1'b1;

    // Commutation POS -> NEG
    i = 5'b00001;
    tick();
    exp_out("start_pos", 4'b1001, 1'b0);
    chk("start_cnt", sw_cnt, 8'd0);
    commute("pos2neg", 5'b00101, 4'b0110);
    chk("pos2neg_cnt", sw_cnt, 8'd1);

    // Priority: quar_delay forces OFF immediately
    i = 5'b11111;
    tick();
    exp_out("quar_off", 4'b0000, 1'b0);
    chk("quar_cnt", sw_cnt, 8'd1);
    i = 5'b00001;
    tick();
    exp_out("idle_pos", 4'b1001, 1'b0);
    commute("pos2free", 5'b10001, 4'b0101);
    chk("pos2free_cnt", sw_cnt, 8'd2);

    // Half power: FREE -> POS first (toggle is 0), then alternate on each 4f tick
    commute("half_entry", 5'b00011, 4'b1001);
    chk("half_entry_cnt", sw_cnt, 8'd3);
    for (int p = 0; p < 4; p++) begin
      clk_4f_en = 1'b1;
      tick();
      clk_4f_en = 1'b0;
      exp_out("half_tick_edge", (p % 2 == 0) ? 4'b1001 : 4'b0101, 1'b0);
      commute("half_alt", 5'b00011, (p % 2 == 0) ? 4'b0101 : 4'b1001);
      for (int s = 0; s < 8 - (DT + 2); s++) begin
        tick();
        exp_out("half_hold", (p % 2 == 0) ? 4'b0101 : 4'b1001, 1'b0);
      end
    end
    chk("half_cnt", sw_cnt, 8'd7);

    // Asynchronous reset mid-DEAD (mid-DRIVE in the no-dead-time build)
    i = 5'b00101;
    tick();
    exp_out("pre_rst", (DT > 0) ? 4'b0000 : 4'b0110, (DT > 0) ? 1'b1 : 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_out("async_rst", 4'b0000, 1'b0);
    chk("async_rst_cnt", sw_cnt, 8'd0);
    #2 rst_n = 1'b1;
    i = 5'b00001;
    tick();
    exp_out("post_rst_pos", 4'b1001, 1'b0);

    // Stop from DRIVE: no dead window, counter cleared
    commute("pre_stop", 5'b00101, 4'b0110);
    chk("pre_stop_cnt", sw_cnt, 8'd1);
    i = 5'b00100;
    tick();
    exp_out("stop", 4'b0000, 1'b0);
    chk("stop_cnt", sw_cnt, 8'd0);
    tick();
    exp_out("stop_hold", 4'b0000, 1'b0);

`ifdef BRI_DEADTIME_EN
    // state_start falls during DEAD: window completes, exit goes to IDLE
    i = 5'b00001;
    tick();
    i = 5'b00101;
    tick();
    exp_out("dead_stop_enter", 4'b0000, 1'b1);
    i = 5'b00100;
    for (int k = 1; k < DT; k++) begin
      tick();
      exp_out("dead_stop_win", 4'b0000, 1'b1);
    end
    tick();
    exp_out("dead_stop_exit", 4'b0000, 1'b0);
    chk("dead_stop_cnt", sw_cnt, 8'd0);
`endif

    // Saturation over 300 commutations
    i = 5'b00001;
    tick();
    exp_out("sat_start", 4'b1001, 1'b0);
    for (int n = 1; n <= 300; n++) begin
      i = (n % 2 == 1) ? 5'b00101 : 5'b00001;
      repeat (DT + 1) tick();
      if (n == 254) chk("sat_254", sw_cnt, 8'd254);
      if (n == 255) chk("sat_255", sw_cnt, 8'd255);
    end
    chk("sat_300", sw_cnt, 8'd255);
    exp_out("sat_gate", 4'b1001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
